// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, data port, memory port and
// stall signals of the unified-memory arbiter.
//   fetch  : if_req, if_addr, if_flush -> if_gnt, if_valid, if_rdata
//   data   : d_req, d_we, d_addr, d_wdata -> d_gnt, d_valid, d_rdata
//   memory : m_en, m_we, m_addr, m_wdata <- m_rdata
//   stalls : stall_if, stall_d
// Modport slave is the arbiter; modport master is the core/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  logic              stall_if;
  logic              stall_d;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           m_en, m_we, m_addr, m_wdata, stall_if, stall_d
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           m_en, m_we, m_addr, m_wdata, stall_if, stall_d
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between the fetch (IF)
// and load/store (D) ports of the core. D has priority, limited by a
// starvation counter so fetch always makes progress.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave (fetch, data, memory, stall signals)
// Grants, memory issue and stalls are combinational; valid/rdata registered.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned STV_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              flush_q, flush_d;
  logic              we_q, we_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              arb_c;
  logic              gnt_d_c;
  logic              gnt_if_c;

  // Arbitration happens in IDLE and in RESP (back-to-back issue).
  always_comb begin
    arb_c    = ~rst & ((state_q == IDLE) | (state_q == RESP));
    gnt_d_c  = arb_c & bus.d_req &
               (~bus.if_req | (starve_q < STV_W'(STARVE_MAX)));
    gnt_if_c = arb_c & bus.if_req & ~gnt_d_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    flush_d    = flush_q;
    we_d       = we_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        flush_d = 1'b0;
        if (gnt_d_c) begin
          state_d = BUSY_D;
          lat_d   = LAT_W'(MEM_LAT - 1);
          we_d    = bus.d_we;
        end else if (gnt_if_c) begin
          state_d = BUSY_IF;
          lat_d   = LAT_W'(MEM_LAT - 1);
          we_d    = 1'b0;
          // A redirect coinciding with the grant already kills this fetch.
          flush_d = bus.if_flush;
        end
        if (~bus.if_req | gnt_if_c) begin
          starve_d = '0;
        end else if (gnt_d_c && (starve_q < STV_W'(STARVE_MAX))) begin
          starve_d = starve_q + STV_W'(1);
        end
      end
      BUSY_IF: begin
        flush_d = flush_q | bus.if_flush;
        if (lat_q == '0) begin
          state_d = RESP;
          if (~(flush_q | bus.if_flush)) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.m_rdata;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      BUSY_D: begin
        if (lat_q == '0) begin
          state_d   = RESP;
          d_valid_d = 1'b1;
          d_rdata_d = we_q ? '0 : bus.m_rdata;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      starve_q   <= '0;
      flush_q    <= 1'b0;
      we_q       <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      flush_q    <= flush_d;
      we_q       <= we_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Memory issue is muxed from the winner and zero outside the issue cycle.
  always_comb begin
    bus.if_gnt  = gnt_if_c;
    bus.d_gnt   = gnt_d_c;
    bus.m_en    = gnt_if_c | gnt_d_c;
    bus.m_we    = gnt_d_c & bus.d_we;
    bus.m_addr  = gnt_d_c ? bus.d_addr : (gnt_if_c ? bus.if_addr : '0);
    bus.m_wdata = gnt_d_c ? bus.d_wdata : '0;
  end

  // A flush arriving during the response cycle still hides the fetch.
  always_comb begin
    bus.if_valid = if_valid_q & ~bus.if_flush;
    bus.if_rdata = if_rdata_q;
    bus.d_valid  = d_valid_q;
    bus.d_rdata  = d_rdata_q;
    bus.stall_if = ~rst & bus.if_req & ~bus.if_valid;
    bus.stall_d  = ~rst & bus.d_req & ~bus.d_valid;
  end

endmodule
